// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: owns the PC, addresses the
// instruction ROM, and handles stall, redirect and the syscall halt/resume handshake.
module fetch_stage #(
  parameter logic [31:0] PC_RESET        = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  input  logic                       resume,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       id_valid,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_pc4,
  output logic [31:0]                id_instr,
  output logic [5:0]                 op,
  output logic [5:0]                 funct,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [15:0]                imm16,
  output logic                       halted,
  output logic [31:0]                fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_RESET;
      state       <= RUN;
      halted      <= 1'b0;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= '0;
      fetch_count <= '0;
    end else if (redirect) begin
      // Wins over halt: a syscall alongside a redirect is on the wrong path.
      pc       <= redirect_pc & ~32'h3;
      state    <= RUN;
      halted   <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (state == HALTED) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      if (resume && !halt) begin
        state  <= RUN;
        halted <= 1'b0;
      end
    end else if (halt) begin
      state    <= HALTED;
      halted   <= 1'b1;
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (!stall) begin
      id_instr    <= imem_rdata;
      id_pc       <= pc;
      id_valid    <= 1'b1;
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_addr = pc[IMEM_ADDR_WIDTH+1:2];
  assign id_pc4    = id_pc + 32'd4;
  assign op        = id_instr[31:26];
  assign rs        = id_instr[25:21];
  assign rt        = id_instr[20:16];
  assign rd        = id_instr[15:11];
  assign shamt     = id_instr[10:6];
  assign funct     = id_instr[5:0];
  assign imm16     = id_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid, halted;
  logic [31:0] id_pc, id_pc4, id_instr, fetch_count;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  logic [31:0] rom [1024];
  assign imem_rdata = rom[imem_addr];

  fetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .resume(resume), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
    .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model of the architectural state.
  logic [31:0] m_pc, m_idpc, m_instr, m_count;
  logic        m_valid, m_halted;

  function automatic logic [187:0] obs();
    return {id_valid, id_pc, id_pc4, id_instr, halted, fetch_count, imem_addr,
            op, rs, rt, rd, shamt, funct, imm16};
  endfunction

  function automatic logic [187:0] expv();
    logic [31:0] i;
    i = m_instr;
    return {m_valid, m_idpc, m_idpc + 32'd4, i, m_halted, m_count, m_pc[11:2],
            i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0], i[15:0]};
  endfunction

  task automatic step(input logic r, input logic st, input logic rdir,
                      input logic [31:0] rpc, input logic h, input logic res);
    rst = r; stall = st; redirect = rdir; redirect_pc = rpc; halt = h; resume = res;
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_idpc = 32'h0; m_instr = 32'h0;
      m_halted = 1'b0; m_count = 32'h0;
    end else if (rdir) begin
      m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_instr = 32'h0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0; m_instr = 32'h0;
      if (res && !h) m_halted = 1'b0;
    end else if (h) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
    end else if (!st) begin
      m_instr = rom[(m_pc / 4) % 1024];
      m_idpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_model got %h exp %h", obs(), expv());
    end
    checks++;
    if ({id_valid, id_pc, id_instr, halted, fetch_count, op, funct} !== '0) begin
      errors++; $display("FAIL reset_zero got v=%b pc=%h i=%h h=%b cnt=%h", id_valid, id_pc, id_instr, halted, fetch_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'hA000_000A; exp_i[1] = 32'hB000_000B;
    exp_i[2] = 32'hC000_000C; exp_i[3] = 32'hD000_000D;
    for (int i = 0; i < 4; i++) rom[i] = exp_i[i];
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (id_instr !== exp_i[i] || id_pc !== 32'(i * 4) || obs() !== expv()) begin
        errors++; $display("FAIL seq_fetch%0d got i=%h pc=%h exp i=%h pc=%h", i, id_instr, id_pc, exp_i[i], i * 4);
      end
    end
    checks++;
    if (fetch_count !== 32'd4) begin
      errors++; $display("FAIL seq_count got %0d exp 4", fetch_count);
    end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (id_instr !== 32'hB000_000B || imem_addr !== 10'd2 || obs() !== expv()) begin
        errors++; $display("FAIL stall_hold%0d got i=%h addr=%0d exp i=b000000b addr=2", i, id_instr, imem_addr);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (id_instr !== 32'hC000_000C || id_pc !== 32'h8 || obs() !== expv()) begin
      errors++; $display("FAIL stall_release got i=%h pc=%h exp i=c000000c pc=8", id_instr, id_pc);
    end
  endtask

  task automatic test_redirect_stall();
    step(0, 1, 1, 32'h43, 0, 0);
    checks++;
    if (imem_addr !== 10'h10 || id_valid !== 1'b0 || id_instr !== 32'h0 || obs() !== expv()) begin
      errors++; $display("FAIL redirect_flush got addr=%h v=%b i=%h exp addr=10 v=0 i=0", imem_addr, id_valid, id_instr);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (id_pc !== 32'h40 || id_valid !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL redirect_target got pc=%h v=%b exp pc=40 v=1", id_pc, id_valid);
    end
  endtask

  task automatic test_halt_resume();
    logic [9:0] held;
    step(0, 0, 0, 0, 1, 0);
    held = imem_addr;
    checks++;
    if (halted !== 1'b1 || id_valid !== 1'b0 || obs() !== expv()) begin
      errors++; $display("FAIL halt_enter got h=%b v=%b exp h=1 v=0", halted, id_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 0, 0, i == 3, 0);
      checks++;
      if (imem_addr !== held || halted !== 1'b1 || id_valid !== 1'b0 || obs() !== expv()) begin
        errors++; $display("FAIL halt_frozen%0d got addr=%h h=%b v=%b exp addr=%h h=1 v=0", i, imem_addr, halted, id_valid, held);
      end
    end
    step(0, 0, 0, 0, 1, 1);
    checks++;
    if (halted !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL halt_and_resume got h=%b exp h=1", halted);
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || id_valid !== 1'b0 || obs() !== expv()) begin
      errors++; $display("FAIL resume_exit got h=%b v=%b exp h=0 v=0", halted, id_valid);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (id_pc[11:2] !== held || id_valid !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL resume_fetch got pc=%h v=%b exp addr=%h v=1", id_pc, id_valid, held);
    end
  endtask

  task automatic test_halt_redirect();
    step(0, 0, 1, 32'h0000_0100, 1, 0);
    checks++;
    if (halted !== 1'b0 || imem_addr !== 10'h40 || obs() !== expv()) begin
      errors++; $display("FAIL halt_redirect got h=%b addr=%h exp h=0 addr=40", halted, imem_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || imem_addr !== 10'h0 || obs() !== expv()) begin
      errors++; $display("FAIL pc_wrap got pc=%h pc4=%h addr=%h exp pc=fffffffc pc4=0 addr=0", id_pc, id_pc4, imem_addr);
    end
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    checks++;
    if ({id_valid, id_pc, id_instr, halted, fetch_count, imem_addr} !== '0 || obs() !== expv()) begin
      errors++; $display("FAIL reset_mid_halt got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic r, st, rdir, h, res;
    logic [31:0] rpc;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(63) == 0);
      rdir = ($urandom_range(15) == 0);
      h    = ($urandom_range(15) == 0);
      res  = ($urandom_range(3) == 0);
      st   = ($urandom_range(3) == 0);
      rpc  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(4095));
      step(r, st, rdir, rpc, h, res);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random%0d got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    m_pc = '0; m_idpc = '0; m_instr = '0; m_count = '0; m_valid = 1'b0; m_halted = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_halt_resume();
    test_halt_redirect();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
